// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory responder for the MEM stage.
// Holds ready low to freeze the pipeline while an access is in flight.
module data_mem_responder #(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned ADDR_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        addr_err
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [32:0] LO_LIM   = 33'(BASE_ADDR);
    localparam logic [32:0] HI_LIM   = 33'(BASE_ADDR) + 33'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_r;
    logic              lat_w;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;

    // Storage is zero at power-up and deliberately untouched by reset.
    logic [31:0]       mem [DEPTH] = '{default: '0};

    logic              req;
    logic [31:0]       offset;
    logic [ADDR_W-1:0] idx;
    logic              legal;
    logic              finish;

    assign req    = MEM_R_EN | MEM_W_EN;
    assign ready  = (state == DONE) | ((state == IDLE) & ~req);
    assign offset = lat_addr - BASE_ADDR;
    assign idx    = ADDR_W'(offset >> 2);
    assign finish = (state == BUSY) & (cnt == 4'd0);

    // 33-bit compares so the upper bound cannot wrap near 2^32.
    assign legal = ({1'b0, lat_addr} >= LO_LIM)
                 & ({1'b0, lat_addr} < HI_LIM)
                 & (lat_addr[1:0] == 2'b00);

    // Sequencer: capture request, count busy cycles, register results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rdata     <= '0;
            addr_err  <= 1'b0;
            lat_r     <= 1'b0;
            lat_w     <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        state     <= BUSY;
                        cnt       <= CNT_INIT;
                        lat_r     <= MEM_R_EN;
                        lat_w     <= MEM_W_EN;
                        lat_addr  <= address;
                        lat_wdata <= wdata;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        if (!legal) begin
                            addr_err <= 1'b1;
                            rdata    <= '0;
                        end else begin
                            addr_err <= 1'b0;
                            // a combined read+write is treated as a store
                            if (lat_r && !lat_w) begin
                                rdata <= mem[idx];
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    // never re-arm here, so a held request is served once
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Array write on completion of a legal store; gated off during reset
    always_ff @(posedge clk) begin
        if (rst && finish && legal && lat_w) begin
            mem[idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder.
// Driver queues expected results; a negedge monitor checks completions.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en;
    logic        w_en;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ready;
    logic [31:0] rdata;
    logic        addr_err;

    logic        r1;
    logic        r15;
    logic        rdy1;
    logic        rdy15;
    logic [31:0] rd1;
    logic [31:0] rd15;
    logic        ae1;
    logic        ae15;

    int checks = 0;
    int errors = 0;
    int wait_cyc = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] er;
        logic        ee;
        int          gap;
    } vec_t;

    exp_t sb[$];
    exp_t e;

    // gap = idle cycles after the access; 0 keeps the request held
    vec_t vecs [18] = '{
        '{1'b0, 1'b1, 32'd1028,       32'hDEADBEEF, 32'h0,        1'b0, 1},
        '{1'b1, 1'b0, 32'd1028,       32'h0,        32'hDEADBEEF, 1'b0, 2},
        '{1'b1, 1'b0, 32'd1020,       32'h0,        32'h0,        1'b1, 1},
        '{1'b1, 1'b0, 32'd1026,       32'h0,        32'h0,        1'b1, 1},
        '{1'b1, 1'b0, 32'd1280,       32'h0,        32'h0,        1'b1, 1},
        '{1'b1, 1'b0, 32'd1276,       32'h0,        32'h0,        1'b0, 1},
        '{1'b1, 1'b0, 32'd0,          32'h0,        32'h0,        1'b1, 1},
        '{1'b1, 1'b0, 32'hFFFFFFFC,   32'h0,        32'h0,        1'b1, 1},
        '{1'b0, 1'b1, 32'd1276,       32'h0BADF00D, 32'h0,        1'b0, 0},
        '{1'b1, 1'b0, 32'd1276,       32'h0,        32'h0BADF00D, 1'b0, 1},
        '{1'b1, 1'b1, 32'd1032,       32'h12345678, 32'h0BADF00D, 1'b0, 1},
        '{1'b1, 1'b0, 32'd1032,       32'h0,        32'h12345678, 1'b0, 0},
        '{1'b0, 1'b1, 32'd1040,       32'h11111111, 32'h12345678, 1'b0, 0},
        '{1'b1, 1'b0, 32'd1040,       32'h0,        32'h11111111, 1'b0, 0},
        '{1'b0, 1'b1, 32'd1040,       32'h22222222, 32'h11111111, 1'b0, 0},
        '{1'b1, 1'b0, 32'd1040,       32'h0,        32'h22222222, 1'b0, 0},
        '{1'b1, 1'b0, 32'd1044,       32'h0,        32'h0,        1'b0, 1},
        '{1'b1, 1'b0, 32'd1028,       32'h0,        32'hDEADBEEF, 1'b0, 1}
    };

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk      (clk),
        .rst      (rst),
        .MEM_R_EN (r_en),
        .MEM_W_EN (w_en),
        .address  (addr),
        .wdata    (wd),
        .ready    (ready),
        .rdata    (rdata),
        .addr_err (addr_err)
    );

    data_mem_responder #(.LATENCY(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .MEM_R_EN (r1),
        .MEM_W_EN (1'b0),
        .address  (32'd1024),
        .wdata    (32'd0),
        .ready    (rdy1),
        .rdata    (rd1),
        .addr_err (ae1)
    );

    data_mem_responder #(.LATENCY(15)) dut15 (
        .clk      (clk),
        .rst      (rst),
        .MEM_R_EN (r15),
        .MEM_W_EN (1'b0),
        .address  (32'd1024),
        .wdata    (32'd0),
        .ready    (rdy15),
        .rdata    (rd15),
        .addr_err (ae15)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per completion (req high, ready high)
    always @(negedge clk) begin
        if (!rst) begin
            wait_cyc = 0;
        end else if (r_en | w_en) begin
            if (!ready) begin
                wait_cyc++;
            end else begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_completion: got completion, expected none");
                end else begin
                    e = sb.pop_front();
                    chk("rdata", rdata, e.rd);
                    chk("addr_err", 32'(addr_err), 32'(e.err));
                    chk("latency", 32'(wait_cyc), 32'd3);
                end
                wait_cyc = 0;
            end
        end else begin
            chk("idle_ready", 32'(ready), 32'd1);
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (ready) break;
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ready in 40 cycles, expected ready", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input vec_t v);
        exp_t x;
        x.rd  = v.er;
        x.err = v.ee;
        sb.push_back(x);
        r_en = v.r;
        w_en = v.w;
        addr = v.a;
        wd   = v.d;
        wait_done("access");
    endtask

    task automatic idle(input int n);
        r_en = 1'b0;
        w_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lat_probe(input bit big);
        int n;
        int lim;
        n   = 0;
        lim = big ? 60 : 40;
        if (big) r15 = 1'b1;
        else     r1  = 1'b1;
        while (n < lim) begin
            @(negedge clk);
            if (big ? rdy15 : rdy1) break;
            n++;
        end
        if (big) begin
            chk("lat15_cycle", 32'(n), 32'd16);
            chk("lat15_rdata", rd15, 32'h0);
            chk("lat15_err", 32'(ae15), 32'd0);
        end else begin
            chk("lat1_cycle", 32'(n), 32'd2);
            chk("lat1_rdata", rd1, 32'h0);
            chk("lat1_err", 32'(ae1), 32'd0);
        end
        @(posedge clk);
        #1;
        r1  = 1'b0;
        r15 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t x;
        rst  = 1'b0;
        r_en = 1'b0;
        w_en = 1'b0;
        addr = '0;
        wd   = '0;
        r1   = 1'b0;
        r15  = 1'b0;
        #3;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_err", 32'(addr_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        foreach (vecs[i]) begin
            issue(vecs[i]);
            if (vecs[i].gap > 0) idle(vecs[i].gap);
        end

        // store interrupted by reset; only the restarted access completes
        x.rd  = 32'h0;
        x.err = 1'b0;
        sb.push_back(x);
        r_en = 1'b0;
        w_en = 1'b1;
        addr = 32'd1036;
        wd   = 32'hAAAA5555;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_err", 32'(addr_err), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_done("restart");
        idle(1);
        issue('{1'b1, 1'b0, 32'd1036, 32'h0, 32'hAAAA5555, 1'b0, 1});
        idle(2);

        lat_probe(1'b0);
        lat_probe(1'b1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, giving the number of BUSY cycles per access (legal range 1..15).
REQ-002 The block SHALL have parameter BASE_ADDR, default 1024, giving the byte address mapped to word 0.
REQ-003 The block SHALL have parameter ADDR_W, default 6, giving log2 of the word depth (default 64 words of 32 bits).
REQ-004 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the asynchronous, active-low reset.
REQ-006 Port MEM_R_EN, input, 1, SHALL be the read request from the pipeline MEM stage.
REQ-007 Port MEM_W_EN, input, 1, SHALL be the write request from the pipeline MEM stage.
REQ-008 Port address, input, 32, SHALL be the byte address of the access.
REQ-009 Port wdata, input, 32, SHALL be the store data.
REQ-010 Port ready, output, 1, SHALL be low while the pipeline must freeze.
REQ-011 Port rdata, output, 32, SHALL be the registered read data.
REQ-012 Port addr_err, output, 1, SHALL flag a completed access to an illegal address.

Function
REQ-013 States SHALL be IDLE, BUSY and DONE, encoded internally.
REQ-014 req SHALL equal MEM_R_EN OR MEM_W_EN.
REQ-015 The initiator SHALL hold MEM_R_EN, MEM_W_EN, address and wdata stable while ready=0; the responder SHALL latch them on the IDLE->BUSY edge and SHALL ignore the inputs afterwards.
REQ-016 IDLE with req=1 SHALL go to BUSY, load the wait counter with LATENCY-1, and latch the request.
REQ-017 IDLE with req=0 SHALL remain in IDLE.
REQ-018 BUSY SHALL decrement the counter and SHALL go to DONE on the edge where the counter equals 0.
REQ-019 DONE SHALL return unconditionally to IDLE on the next edge, so that a held request is never serviced twice.
REQ-020 ready SHALL be combinational: 1 in DONE, 1 in IDLE when req=0, and 0 otherwise.
REQ-021 Access latency SHALL be as follows: with the request first seen in cycle 0, ready SHALL be 1 in cycle LATENCY+1 and 0 in cycles 0..LATENCY.
REQ-022 Word index SHALL be bits [ADDR_W+1:2] of (address - BASE_ADDR), computed in 32-bit unsigned arithmetic.
REQ-023 An address SHALL be illegal if address < BASE_ADDR, address >= BASE_ADDR + 4*2^ADDR_W, or address[1:0] != 0.
REQ-024 On the BUSY->DONE edge, a legal write SHALL update the array word, and a legal read SHALL load rdata from the array.
REQ-025 On the same edge, an illegal access SHALL set addr_err=1, SHALL suppress the write, and SHALL load rdata with 0.
REQ-026 On that edge, a legal access SHALL set addr_err=0.
REQ-027 When MEM_R_EN and MEM_W_EN are both 1, the block SHALL perform the write only and SHALL leave rdata unchanged.
REQ-028 A write completion SHALL leave rdata unchanged.
REQ-029 rdata and addr_err SHALL hold their values until the next completion.
REQ-030 A read of a word written by the immediately preceding access SHALL return the new value.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE, counter=0, rdata=0 and addr_err=0, independent of clk.
REQ-032 After reset, ready SHALL equal NOT req.
REQ-033 Array contents SHALL NOT be affected by rst and SHALL be initialised to 0 at time zero.
REQ-034 Reset asserted during BUSY SHALL abort the access with no array write; a still-held request SHALL restart from IDLE after deassertion.

Verification
REQ-035 Scenario, LATENCY=2: write 0xDEADBEEF to 1028 presented in cycle 0 -> ready 0 in cycles 0-2 and 1 in cycle 3; a subsequent read of 1028 SHALL give rdata=0xDEADBEEF and addr_err=0, with ready high 3 cycles after that request.
REQ-036 Scenario: reads of 1020, 1026 and 1280 -> each completes with addr_err=1 and rdata=0; a read of 1276 SHALL give addr_err=0.
REQ-037 Scenario: MEM_R_EN=MEM_W_EN=1, address 1032, wdata 0x12345678 -> rdata unchanged at completion, and a later read of 1032 SHALL return 0x12345678.
REQ-038 Scenario: rst pulsed low mid-BUSY of a write of 0xAAAA5555 to 1036 -> rdata=0, addr_err=0 and state IDLE asynchronously; the write SHALL complete only after the held request restarts, taking the full latency.
REQ-039 Scenario: back-to-back requests held continuously across DONE -> exactly one array access per request, with ready high for exactly one cycle per request.
REQ-040 Scenario: LATENCY=1 and LATENCY=15 builds -> ready rises in cycle 2 and cycle 16 respectively.
